// File: rtl/ign_bank_pkg.sv
// rtl/ign_bank_pkg.sv - shared encodings for the ignition channel bank
package ign_bank_pkg;

   typedef enum logic [1:0] {
      MODE_INDEP  = 2'd0,
      MODE_DIST   = 2'd1,
      MODE_WASTED = 2'd2,
      MODE_RSVD   = 2'd3
   } ign_mode_e;

   typedef enum logic [1:0] {
      CH_IDLE    = 2'd0,
      CH_DWELL   = 2'd1,
      CH_LOCKOUT = 2'd2
   } ch_state_e;

endpackage

// File: rtl/ign_channel.sv
// rtl/ign_channel.sv - one coil: angle window, shadowed angles, dwell FSM, over-dwell guard
module ign_channel
   import ign_bank_pkg::*;
#(
   parameter int ANG_W = 16,
   parameter int TMO_W = 32
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             enable,
   input  logic             ch_en,
   input  logic [ANG_W-1:0] eng_phase,
   input  logic [ANG_W-1:0] qpr,
   input  logic [ANG_W-1:0] ign_timing,
   input  logic [ANG_W-1:0] dwell,
   input  logic [ANG_W-1:0] ch_phase,
   input  logic [TMO_W-1:0] max_dwell,
   input  logic             fault_clr,
   output logic             dwell_nxt,
   output logic             fault
);

   ch_state_e        state, state_nxt;
   logic [TMO_W-1:0] cnt, cnt_nxt;
   logic [ANG_W-1:0] fire_sh, start_sh;
   logic [ANG_W-1:0] fire_live, start_live, dwell_eff;
   logic [ANG_W-1:0] win_f, win_s;
   logic [ANG_W:0]   qpr_x, fire_sum, start_sum;
   logic             in_win, fault_set;

   // Operands are < qpr, so one conditional subtract brings each sum back into range.
   always_comb begin
      qpr_x      = {1'b0, qpr};
      dwell_eff  = (dwell >= qpr) ? qpr - ANG_W'(1) : dwell;
      fire_sum   = {1'b0, ch_phase} + qpr_x - {1'b0, ign_timing};
      fire_live  = ANG_W'((fire_sum >= qpr_x) ? fire_sum - qpr_x : fire_sum);
      start_sum  = {1'b0, fire_live} + qpr_x - {1'b0, dwell_eff};
      start_live = ANG_W'((start_sum >= qpr_x) ? start_sum - qpr_x : start_sum);
   end

   // Live angles arm the window; once active, the latched copy decides when it closes.
   always_comb begin
      win_f = (state == CH_IDLE) ? fire_live  : fire_sh;
      win_s = (state == CH_IDLE) ? start_live : start_sh;
      if (win_s <= win_f)
         in_win = (eng_phase >= win_s) && (eng_phase < win_f);
      else
         in_win = (eng_phase >= win_s) || (eng_phase < win_f);
   end

   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      fault_set = 1'b0;
      if (!enable || !ch_en) begin
         state_nxt = CH_IDLE;
      end else begin
         case (state)
            CH_IDLE: begin
               if (in_win) begin
                  state_nxt = CH_DWELL;
                  cnt_nxt   = '0;
               end
            end
            CH_DWELL: begin
               if (!in_win) begin
                  state_nxt = CH_IDLE;
               end else if ((max_dwell != '0) && (cnt == max_dwell - TMO_W'(1))) begin
                  state_nxt = CH_LOCKOUT;
                  fault_set = 1'b1;
               end else if (cnt != '1) begin
                  cnt_nxt = cnt + TMO_W'(1);
               end
            end
            CH_LOCKOUT: begin
               if (!in_win) state_nxt = CH_IDLE;
            end
            default: state_nxt = CH_IDLE;
         endcase
      end
   end

   assign dwell_nxt = (state_nxt == CH_DWELL);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state    <= CH_IDLE;
         cnt      <= '0;
         fire_sh  <= '0;
         start_sh <= '0;
         fault    <= 1'b0;
      end else begin
         state <= state_nxt;
         cnt   <= cnt_nxt;
         if (state == CH_IDLE) begin
            fire_sh  <= fire_live;
            start_sh <= start_live;
         end
         if (fault_set)
            fault <= 1'b1;
         else if (fault_clr)
            fault <= 1'b0;
      end
   end

endmodule

// File: rtl/ign_bank.sv
// rtl/ign_bank.sv - N_CH ignition channels with registered coil output routing
module ign_bank
   import ign_bank_pkg::*;
#(
   parameter int N_CH  = 4,
   parameter int ANG_W = 16,
   parameter int TMO_W = 32
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  enable,
   input  logic [ANG_W-1:0]      eng_phase,
   input  logic [ANG_W-1:0]      qpr,
   input  logic [ANG_W-1:0]      ign_timing,
   input  logic [ANG_W-1:0]      dwell,
   input  logic [N_CH*ANG_W-1:0] ch_phase,
   input  logic [N_CH-1:0]       ch_en,
   input  logic [1:0]            mode,
   input  logic [TMO_W-1:0]      max_dwell,
   input  logic                  fault_clr,
   output logic [N_CH-1:0]       ign_out,
   output logic [N_CH-1:0]       fault
);

   logic [N_CH-1:0] raw_nxt;
   logic [N_CH-1:0] routed;

   for (genvar g = 0; g < N_CH; g++) begin : g_ch
      ign_channel #(
         .ANG_W(ANG_W),
         .TMO_W(TMO_W)
      ) u_ch (
         .clk       (clk),
         .reset     (reset),
         .enable    (enable),
         .ch_en     (ch_en[g]),
         .eng_phase (eng_phase),
         .qpr       (qpr),
         .ign_timing(ign_timing),
         .dwell     (dwell),
         .ch_phase  (ch_phase[g*ANG_W +: ANG_W]),
         .max_dwell (max_dwell),
         .fault_clr (fault_clr),
         .dwell_nxt (raw_nxt[g]),
         .fault     (fault[g])
      );
   end

   // Routing acts on next-state raw bits so the coil pin is the single register stage.
   always_comb begin
      routed = '0;
      case (ign_mode_e'(mode))
         MODE_DIST: routed[0] = |raw_nxt;
         MODE_WASTED: begin
            for (int i = 0; i < N_CH/2; i++)
               routed[i] = raw_nxt[i] | raw_nxt[i + N_CH/2];
         end
         default: routed = raw_nxt;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset)
         ign_out <= '0;
      else
         ign_out <= routed;
   end

endmodule

// File: tb/tb_ign_bank.sv
// tb/tb_ign_bank.sv - directed and randomized checks of ign_bank against a behavioural model
module tb_ign_bank;

   localparam int N_CH  = 4;
   localparam int ANG_W = 16;
   localparam int TMO_W = 32;

   logic                  clk;
   logic                  reset;
   logic                  enable;
   logic [ANG_W-1:0]      eng_phase;
   logic [ANG_W-1:0]      qpr;
   logic [ANG_W-1:0]      ign_timing;
   logic [ANG_W-1:0]      dwell;
   logic [N_CH*ANG_W-1:0] ch_phase;
   logic [N_CH-1:0]       ch_en;
   logic [1:0]            mode;
   logic [TMO_W-1:0]      max_dwell;
   logic                  fault_clr;
   logic [N_CH-1:0]       ign_out;
   logic [N_CH-1:0]       fault;

   ign_bank #(.N_CH(N_CH), .ANG_W(ANG_W), .TMO_W(TMO_W)) dut (
      .clk       (clk),
      .reset     (reset),
      .enable    (enable),
      .eng_phase (eng_phase),
      .qpr       (qpr),
      .ign_timing(ign_timing),
      .dwell     (dwell),
      .ch_phase  (ch_phase),
      .ch_en     (ch_en),
      .mode      (mode),
      .max_dwell (max_dwell),
      .fault_clr (fault_clr),
      .ign_out   (ign_out),
      .fault     (fault)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_bad = 0;

   bit              m_act  [N_CH];
   bit              m_lock [N_CH];
   int              m_plen [N_CH];
   int              m_shf  [N_CH];
   int              m_shs  [N_CH];
   logic [N_CH-1:0] m_fault;
   logic [N_CH-1:0] m_out;

   int rise_ph, fall_ph, rise_cnt, hi_len, rc0;
   bit prev_o0, upper_seen;

   function automatic int modq(int a, int q);
      return ((a % q) + q) % q;
   endfunction

   task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      for (int i = 0; i < N_CH; i++) begin
         m_act[i] = 0; m_lock[i] = 0; m_plen[i] = 0; m_shf[i] = 0; m_shs[i] = 0;
      end
      m_fault = '0;
      m_out   = '0;
      prev_o0 = 1'b0;
   endtask

   // Window membership as modular distance from the start angle.
   task automatic model_edge();
      logic [N_CH-1:0] raw;
      int q, p, f, s, de, wf, ws;
      bit idle, w, fset;
      q   = int'(qpr);
      p   = int'(eng_phase);
      raw = '0;
      for (int i = 0; i < N_CH; i++) begin
         f    = modq(int'(ch_phase[i*ANG_W +: ANG_W]) - int'(ign_timing), q);
         de   = (int'(dwell) >= q) ? q - 1 : int'(dwell);
         s    = modq(f - de, q);
         idle = !m_act[i] && !m_lock[i];
         wf   = idle ? f : m_shf[i];
         ws   = idle ? s : m_shs[i];
         w    = modq(p - ws, q) < modq(wf - ws, q);
         fset = 0;
         if (!enable || !ch_en[i]) begin
            m_act[i] = 0; m_lock[i] = 0;
         end else if (m_act[i]) begin
            if (!w) m_act[i] = 0;
            else if (max_dwell != 0 && m_plen[i] == int'(max_dwell)) begin
               m_act[i] = 0; m_lock[i] = 1; fset = 1;
            end else m_plen[i]++;
         end else if (m_lock[i]) begin
            if (!w) m_lock[i] = 0;
         end else if (w) begin
            m_act[i] = 1; m_plen[i] = 1;
         end
         if (idle) begin
            m_shf[i] = f; m_shs[i] = s;
         end
         if (fset) m_fault[i] = 1'b1;
         else if (fault_clr) m_fault[i] = 1'b0;
         raw[i] = m_act[i];
      end
      m_out = '0;
      case (mode)
         2'd1: m_out[0] = |raw;
         2'd2: for (int i = 0; i < N_CH/2; i++) m_out[i] = raw[i] | raw[i + N_CH/2];
         default: m_out = raw;
      endcase
   endtask

   task automatic step();
      int ph;
      ph = int'(eng_phase);
      @(posedge clk);
      model_edge();
      #1;
      chk("ign_out", 32'(ign_out), 32'(m_out));
      chk("fault", 32'(fault), 32'(m_fault));
      if (ign_out[0] && !prev_o0) begin
         rise_ph = ph; rise_cnt++; hi_len = 0;
      end
      if (ign_out[0]) hi_len++;
      if (!ign_out[0] && prev_o0) fall_ph = ph;
      prev_o0 = ign_out[0];
      if (|ign_out[3:2]) upper_seen = 1'b1;
   endtask

   task automatic sweep(int from, int to);
      eng_phase = ANG_W'(from);
      for (int k = 0; k < 20000; k++) begin
         step();
         if (int'(eng_phase) == to) return;
         eng_phase = ANG_W'(modq(int'(eng_phase) + 1, int'(qpr)));
      end
      chk("sweep_bound", 32'(eng_phase), 32'(to));
   endtask

   task automatic pulse_reset();
      reset = 1'b1;
      @(posedge clk);
      #1;
      chk("rst_out", 32'(ign_out), 32'd0);
      chk("rst_fault", 32'(fault), 32'd0);
      reset = 1'b0;
      model_reset();
   endtask

   initial begin
      int q;
      reset = 1'b1; enable = 1'b1; eng_phase = '0; qpr = 16'd15360;
      ign_timing = 16'd1024; dwell = 16'd1280; ch_phase = '0; ch_en = 4'b0001;
      mode = 2'd0; max_dwell = '0; fault_clr = 1'b0;
      rise_ph = -1; fall_ph = -1; rise_cnt = 0; hi_len = 0; upper_seen = 1'b0;
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      chk("reset_out", 32'(ign_out), 32'd0);
      chk("reset_fault", 32'(fault), 32'd0);
      reset = 1'b0;

      // basic window
      sweep(12900, 14500);
      chk("a_rise", rise_ph, 13056);
      chk("a_fall", fall_ph, 14336);
      chk("a_len", hi_len, 1280);

      // window straddling the revolution wrap
      ch_phase[15:0] = 16'd1792;
      sweep(14000, 1000);
      chk("b_rise", rise_ph, 14848);
      chk("b_fall", fall_ph, 768);
      chk("b_len", hi_len, 1280);

      // over-dwell, clear, re-arm, set beats clear
      max_dwell = 32'd100;
      sweep(14700, 1000);
      chk("c_len", hi_len, 100);
      chk("c_fall", fall_ph, 14948);
      chk("c_fault", 32'(fault[0]), 32'd1);
      fault_clr = 1'b1; eng_phase = 16'd1001; step(); fault_clr = 1'b0;
      chk("c_clr", 32'(fault[0]), 32'd0);
      rc0 = rise_cnt;
      sweep(14700, 14947);
      eng_phase = 16'd14948; fault_clr = 1'b1; step(); fault_clr = 1'b0;
      chk("c_rearm", rise_cnt - rc0, 1);
      chk("c_set_wins", 32'(fault[0]), 32'd1);
      sweep(14949, 1000);
      max_dwell = '0;
      fault_clr = 1'b1; eng_phase = 16'd1001; step(); fault_clr = 1'b0;

      // wasted spark
      ch_phase = {16'd0, 16'd7680, 16'd0, 16'd0};
      ch_en = 4'b0101; mode = 2'd2; upper_seen = 1'b0; rc0 = rise_cnt;
      sweep(0, 15359);
      chk("d_pulses", rise_cnt - rc0, 2);
      chk("d_upper", 32'(upper_seen), 32'd0);

      // timing change mid-dwell
      ch_phase = '0; ch_en = 4'b0001; mode = 2'd0;
      sweep(12900, 13500);
      ign_timing = 16'd2048;
      sweep(13501, 14500);
      chk("e_fall_old", fall_ph, 14336);
      sweep(11900, 13500);
      chk("e_rise_new", rise_ph, 12032);
      chk("e_fall_new", fall_ph, 13312);

      // enable drop mid-dwell
      sweep(11900, 12500);
      enable = 1'b0; eng_phase = 16'd12501; step();
      chk("f_out", 32'(ign_out[0]), 32'd0);
      chk("f_fault", 32'(fault), 32'd0);
      enable = 1'b1;
      sweep(12502, 13500);

      // asynchronous reset mid-dwell
      sweep(11900, 12500);
      #3 reset = 1'b1;
      #1;
      chk("g_async", 32'(ign_out), 32'd0);
      @(posedge clk);
      #1 reset = 1'b0;
      model_reset();
      sweep(11900, 13500);
      chk("g_rise", rise_ph, 12032);
      chk("g_fall", fall_ph, 13312);

      // randomized configurations
      for (int r = 0; r < 16; r++) begin
         q          = int'($urandom_range(64, 1200));
         qpr        = ANG_W'(q);
         ign_timing = ANG_W'($urandom_range(0, q - 1));
         dwell      = ANG_W'($urandom_range(0, q + 20));
         for (int i = 0; i < N_CH; i++)
            ch_phase[i*ANG_W +: ANG_W] = ANG_W'($urandom_range(0, q - 1));
         ch_en     = N_CH'($urandom);
         mode      = 2'($urandom_range(0, 3));
         max_dwell = ($urandom_range(0, 2) == 0) ? '0 : TMO_W'($urandom_range(1, q/2));
         eng_phase = ANG_W'($urandom_range(0, q - 1));
         pulse_reset();
         for (int c = 0; c < 1500; c++) begin
            enable    = ($urandom_range(0, 39) != 0);
            fault_clr = ($urandom_range(0, 29) == 0);
            if ($urandom_range(0, 199) == 0)
               ign_timing = ANG_W'($urandom_range(0, q - 1));
            step();
            if ($urandom_range(0, 49) == 0)
               eng_phase = ANG_W'($urandom_range(0, q - 1));
            else
               eng_phase = ANG_W'(modq(int'(eng_phase) + 1, q));
         end
         fault_clr = 1'b0;
         enable = 1'b1;
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
